adc_window_integrator: RTL and testbench



---
 rtl/adc_window_integrator.sv | 140 ++++++++++++++
 tb/tb_adc_window_integrator.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_window_integrator.sv
`default_nettype none
// ============================================================================
// Module      : adc_window_integrator
// Description : Trigger-gated window integrator for the 13-bit signed ADC
//               sample stream. After a trigger rising edge it waits a
//               programmable delay, subtracts a pedestal from each sample,
//               sums a programmable number of samples and presents the sum
//               with a one-cycle valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_window_integrator (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] din,
    input  logic        trig,
    input  logic [7:0]  delay,
    input  logic [5:0]  nsamp,
    input  logic [12:0] pedestal,
    output logic [19:0] sum_out,
    output logic        valid,
    output logic        busy,
    output logic        trig_lost
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_ACCUM = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic        r_trig_d;
    logic [7:0]  r_dcnt;
    logic [5:0]  r_scnt;
    logic [5:0]  r_nsamp_l;
    logic [12:0] r_ped_l;
    logic [19:0] r_acc;
    logic [19:0] r_sum;
    logic        r_valid;
    logic        r_trig_lost;

    logic        w_rise;
    logic [5:0]  w_scnt_inc;
    logic        w_last;
    logic [13:0] w_diff;
    logic [19:0] w_acc_nxt;

    assign w_rise     = trig & ~r_trig_d;
    assign w_scnt_inc = r_scnt + 6'd1;
    // A 6-bit compare lets nsamp = 0 match after the 64th sample (63 + 1 wraps to 0).
    assign w_last     = (r_state == S_ACCUM) && (w_scnt_inc == r_nsamp_l);
    // Both operands sign-extended to 14 bits, so the difference cannot overflow.
    assign w_diff     = {din[12], din} - {r_ped_l[12], r_ped_l};
    assign w_acc_nxt  = r_acc + {{6{w_diff[13]}}, w_diff};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: trigger starts a window, delay counts down, accumulation ends on the Nth sample.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = (delay != 8'd0) ? S_DELAY : S_ACCUM;
                end
            end
            S_DELAY: begin
                if (r_dcnt == 8'd1) begin
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: edge detect, shadow latching, counters, accumulator and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trig_d    <= 1'b1;   // a trigger held high through reset is not an edge
            r_dcnt      <= 8'd0;
            r_scnt      <= 6'd0;
            r_nsamp_l   <= 6'd0;
            r_ped_l     <= 13'd0;
            r_acc       <= 20'd0;
            r_sum       <= 20'd0;
            r_valid     <= 1'b0;
            r_trig_lost <= 1'b0;
        end else begin
            r_trig_d    <= trig;
            r_valid     <= 1'b0;
            r_trig_lost <= w_rise & (r_state != S_IDLE);
            unique case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_dcnt    <= delay;
                        r_nsamp_l <= nsamp;
                        r_ped_l   <= pedestal;
                        r_acc     <= 20'd0;
                        r_scnt    <= 6'd0;
                    end
                end
                S_DELAY: begin
                    r_dcnt <= r_dcnt - 8'd1;
                end
                S_ACCUM: begin
                    r_acc  <= w_acc_nxt;
                    r_scnt <= w_scnt_inc;
                    if (w_last) begin
                        r_sum   <= w_acc_nxt;
                        r_valid <= 1'b1;
                    end
                end
                default: begin
                    r_acc <= 20'd0;
                end
            endcase
        end
    end

    assign sum_out   = r_sum;
    assign valid     = r_valid;
    assign busy      = (r_state != S_IDLE);
    assign trig_lost = r_trig_lost;

endmodule
`default_nettype wire

// File: tb/tb_adc_window_integrator.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_window_integrator
// Description : Directed self-checking bench for adc_window_integrator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_window_integrator;

    logic        clk;
    logic        rst;
    logic [12:0] din;
    logic        trig;
    logic [7:0]  delay;
    logic [5:0]  nsamp;
    logic [12:0] pedestal;
    logic [19:0] sum_out;
    logic        valid;
    logic        busy;
    logic        trig_lost;

    int n_checks;
    int n_fails;

    adc_window_integrator dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .trig      (trig),
        .delay     (delay),
        .nsamp     (nsamp),
        .pedestal  (pedestal),
        .sum_out   (sum_out),
        .valid     (valid),
        .busy      (busy),
        .trig_lost (trig_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        din      = 13'd0;
        trig     = 1'b0;
        delay    = 8'd0;
        nsamp    = 6'd0;
        pedestal = 13'd0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_sum",   $signed(sum_out), 0);
        check("rst_valid", valid, 0);
        check("rst_busy",  busy, 0);
        check("rst_lost",  trig_lost, 0);
        rst = 1'b0;
        tick();

        // ---------------- basic window: 4 x 100 ----------------
        din = 13'd100; delay = 8'd0; nsamp = 6'd4; pedestal = 13'd0; trig = 1'b1;
        tick();                                   // edge k
        check("basic_busy_k", busy, 1);
        check("basic_valid_k", valid, 0);
        trig = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("basic_busy_mid", busy, 1);
            check("basic_valid_mid", valid, 0);
        end
        tick();                                   // edge k+4
        check("basic_valid", valid, 1);
        check("basic_sum", $signed(sum_out), 400);
        check("basic_busy_end", busy, 0);
        tick();
        check("basic_valid_1cyc", valid, 0);
        check("basic_sum_hold", $signed(sum_out), 400);

        // ---------------- delay + pedestal: din = j at edge k+j ----------------
        delay = 8'd3; nsamp = 6'd5; pedestal = 13'd2; din = 13'd0; trig = 1'b1;
        tick();                                   // edge k
        trig = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            din = 13'(j);
            tick();
            check("dly_valid_early", valid, 0);
        end
        din = 13'd8;
        tick();                                   // edge k+8
        check("dly_valid", valid, 1);
        check("dly_sum", $signed(sum_out), 20);   // (4+5+6+7+8) - 5*2

        // ---------------- extremes: 64 samples ----------------
        delay = 8'd0; nsamp = 6'd0; pedestal = 13'sd4095; din = -13'sd4096; trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int i = 1; i <= 63; i++) tick();
        check("neg_valid_early", valid, 0);
        tick();
        check("neg_valid", valid, 1);
        check("neg_sum", $signed(sum_out), -524224);

        pedestal = -13'sd4096; din = 13'sd4095; trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int i = 1; i <= 63; i++) tick();
        check("pos_valid_early", valid, 0);
        tick();
        check("pos_valid", valid, 1);
        check("pos_sum", $signed(sum_out), 524224);

        // ---------------- retrigger: D=2, N=3 ----------------
        delay = 8'd2; nsamp = 6'd3; pedestal = 13'd0; din = 13'd10; trig = 1'b1;
        tick();                                   // edge k
        trig = 1'b0;
        tick();                                   // k+1
        tick();                                   // k+2
        trig = 1'b1;
        tick();                                   // k+3: ignored edge
        check("retrig_lost", trig_lost, 1);
        check("retrig_busy", busy, 1);
        trig = 1'b0;
        tick();                                   // k+4
        check("retrig_lost_1cyc", trig_lost, 0);
        tick();                                   // k+5
        check("retrig_valid", valid, 1);
        check("retrig_sum", $signed(sum_out), 30);
        trig = 1'b1;
        tick();                                   // k+6: accepted
        check("retrig_accept_busy", busy, 1);
        check("retrig_accept_lost", trig_lost, 0);
        check("retrig_accept_valid", valid, 0);
        trig = 1'b0; din = 13'd7;
        for (int i = 1; i <= 4; i++) tick();      // k'+1..k'+4
        trig = 1'b1;
        tick();                                   // k'+5: last ACCUM edge
        check("last_edge_valid", valid, 1);
        check("last_edge_sum", $signed(sum_out), 21);
        check("last_edge_lost", trig_lost, 1);
        tick();                                   // trig still high: no new edge
        check("last_edge_idle", busy, 0);
        check("last_edge_lost_1cyc", trig_lost, 0);
        trig = 1'b0;
        tick();

        // ---------------- shadow latching ----------------
        delay = 8'd1; nsamp = 6'd2; pedestal = 13'd5; din = 13'd20; trig = 1'b1;
        tick();                                   // edge k
        delay = 8'd5; nsamp = 6'd10; pedestal = 13'd0; trig = 1'b0;
        tick();                                   // k+1
        check("shadow_busy", busy, 1);
        tick();                                   // k+2
        check("shadow_valid_early", valid, 0);
        tick();                                   // k+3
        check("shadow_valid", valid, 1);
        check("shadow_sum", $signed(sum_out), 30);
        trig = 1'b1;
        tick();                                   // m: first IDLE edge, accepted
        check("shadow2_busy", busy, 1);
        trig = 1'b0;
        for (int i = 1; i <= 14; i++) tick();
        check("shadow2_valid_early", valid, 0);
        tick();                                   // m+15
        check("shadow2_valid", valid, 1);
        check("shadow2_sum", $signed(sum_out), 200);

        // ---------------- reset mid-window ----------------
        delay = 8'd0; nsamp = 6'd8; pedestal = 13'd0; din = 13'd50; trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        trig = 1'b1;
        #1;
        check("arst_sum",   $signed(sum_out), 0);
        check("arst_valid", valid, 0);
        check("arst_busy",  busy, 0);
        check("arst_lost",  trig_lost, 0);
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("held_trig_valid", valid, 0);
            check("held_trig_busy", busy, 0);
        end
        trig = 1'b0;
        tick();
        trig = 1'b1;
        tick();
        check("post_rst_busy", busy, 1);
        trig = 1'b0;
        for (int i = 1; i <= 7; i++) tick();
        check("post_rst_valid_early", valid, 0);
        tick();
        check("post_rst_valid", valid, 1);
        check("post_rst_sum", $signed(sum_out), 400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
